serial_adder: RTL and testbench

- Parameterised bit-serial adder/subtractor built around a 1-bit full-adder slice with a registered carry.
- Processes one bit per clock, LSB first, so one slice of area serves any WIDTH.
- Accepts an operand pair with a start/busy/done handshake and holds the result until the next operation.
- Serves as the area-minimal arithmetic unit for multi-cycle datapaths in the codebase.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/fa_bit_slice.sv | 41 ++++
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state
// encodings and mode selector values.
package serial_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/fa_bit_slice.sv
// One-bit full-adder slice with a registered carry. The carry can be
// preloaded (initial carry of an operation) or advanced from the slice.
module fa_bit_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  input  logic load_i,
  input  logic load_val_i,
  input  logic en_i,
  output logic s_o,
  output logic c_o,
  output logic carry_q_o
);

  logic carry_q;
  logic carry_d;

  assign s_o       = a_i ^ b_i ^ carry_q;
  assign c_o       = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
  assign carry_q_o = carry_q;

  // Load takes priority: it only happens while the top is idle.
  always_comb begin
    carry_d = carry_q;
    if (load_i) begin
      carry_d = load_val_i;
    end else if (en_i) begin
      carry_d = c_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule : fa_bit_slice

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice processes the operands
// LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             state_dbg
);

  // Handshake: start is sampled only on edges where busy=0; the result
  // is valid from the done pulse until the next accepted start.
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  res_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              carry_load, carry_load_val, carry_en;
  logic              slice_s, slice_c, carry_q;
  logic              last_bit;

  fa_bit_slice u_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_i        (a_sh_q[0]),
    .b_i        (b_sh_q[0]),
    .load_i     (carry_load),
    .load_val_i (carry_load_val),
    .en_i       (carry_en),
    .s_o        (slice_s),
    .c_o        (slice_c),
    .carry_q_o  (carry_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = slice_s;
  end

  always_comb begin
    state_d        = state_q;
    a_sh_d         = a_sh_q;
    b_sh_d         = b_sh_q;
    res_d          = res_q;
    cnt_d          = cnt_q;
    sum_d          = sum_q;
    cout_d         = cout_q;
    ovf_d          = ovf_q;
    done_d         = 1'b0;
    carry_load     = 1'b0;
    carry_load_val = 1'b0;
    carry_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d         = a;
          b_sh_d         = (sub == MODE_SUB) ? ~b : b;
          carry_load     = 1'b1;
          carry_load_val = (sub == MODE_SUB) ? 1'b1 : cin;
          cnt_d          = '0;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_shift;
        carry_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q here is still the carry into the MSB.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          sum_d   = res_shift;
          cout_d  = slice_c;
          ovf_d   = carry_q ^ slice_c;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operations on an 8-bit
// instance plus an exhaustive sweep of a 1-bit instance.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf, st;
  logic [W-1:0] sum;

  logic         start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         busy1, done1, cout1, ovf1, st1;
  logic [0:0]   sum1;

  int n_cmp  = 0;
  int n_fail = 0;

  // {overflow, cout, sum[7:0]}
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .overflow(ovf), .state_dbg(st)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .overflow(ovf1), .state_dbg(st1)
  );

  // Reference: whole-word arithmetic on ints.
  function automatic logic [9:0] model(int w, int aa, int bb, int ci, int sb);
    int mask, hm, bx, c0, full, s, co, cm;
    logic [9:0] r;
    mask = (1 << w) - 1;
    hm   = mask >> 1;
    bx   = sb ? (~bb) & mask : bb & mask;
    c0   = sb ? 1 : ci;
    full = (aa & mask) + bx + c0;
    s    = full & mask;
    co   = (full >> w) & 1;
    cm   = (((aa & hm) + (bx & hm) + c0) >> (w - 1)) & 1;
    r[7:0] = s[7:0];
    r[8]   = co[0];
    r[9]   = cm[0] ^ co[0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic isub);
    a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
    exp_q.push_back(model(W, int'(ia), int'(ib), int'(ic), int'(isub)));
    tick();
    start = 1'b0;
  endtask

  // Walks the W busy cycles, optionally pulsing start (with a new a) at
  // busy cycle inj, then checks the completion cycle.
  task automatic expect_run(input string tag, input int inj, input logic [W-1:0] inj_a);
    logic [9:0] e;
    for (int k = 0; k < W; k++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " done_early"}, done, 1'b0);
      if (k == inj) begin
        a = inj_a; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    e = exp_q.pop_front();
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_end"}, busy, 1'b0);
    chk({tag, " sum"}, sum, e[7:0]);
    chk({tag, " cout"}, cout, e[8]);
    chk({tag, " ovf"}, ovf, e[9]);
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] s_exp);
    tick();
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " sum_hold"}, sum, s_exp);
  endtask

  initial begin
    logic [9:0] e;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    #3;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum, 8'h00);
    chk("rst cout", cout, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    expect_run("ff+01", -1, '0);
    after_done("ff+01", 8'h00);

    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    expect_run("7f+01", -1, '0);
    after_done("7f+01", 8'h80);

    issue(8'h05, 8'h07, 1'b1, 1'b1);
    expect_run("05-07", -1, '0);
    after_done("05-07", 8'hFE);

    issue(8'h10, 8'h20, 1'b0, 1'b0);
    expect_run("ign_start", 3, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ign_start no2nd", done, 1'b0);
      chk("ign_start idle", busy, 1'b0);
    end
    chk("ign_start sum", sum, 8'h30);

    // Reset mid-operation
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort sum", sum, 8'h00);
    chk("abort cout", cout, 1'b0);
    chk("abort ovf", ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      chk("abort no_done", done, 1'b0);
    end

    // Back-to-back: start accepted in the done cycle
    issue(8'h03, 8'h04, 1'b0, 1'b0);
    expect_run("b2b_1", -1, '0);
    issue(8'h09, 8'h01, 1'b0, 1'b0);
    expect_run("b2b_2", -1, '0);
    after_done("b2b_2", 8'h0A);

    // Random operations
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs);
      expect_run("rand", -1, '0);
      if ($urandom_range(0, 1) == 0) tick();
    end

    // WIDTH=1 exhaustive sweep
    for (int v = 0; v < 16; v++) begin
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; sub1 = v[3];
      e = model(1, v & 1, (v >> 1) & 1, (v >> 2) & 1, (v >> 3) & 1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("w1 busy", busy1, 1'b1);
      chk("w1 done_early", done1, 1'b0);
      tick();
      chk("w1 done", done1, 1'b1);
      chk("w1 busy_end", busy1, 1'b0);
      chk("w1 sum", sum1, e[0]);
      chk("w1 cout", cout1, e[8]);
      chk("w1 ovf", ovf1, e[9]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
